ksa_core: RTL and testbench
===========================

Name: ksa_core

Overview:
- Key-scheduling stage of the ARC4 datapath.
- Takes the identity-initialised 256-byte S array from the init stage and permutes it in place under a KEYLEN-byte key.
- Hands the permuted S to the PRGA stage.
- Drives a single-port 256x8 S memory and uses the codebase's en/rdy request handshake.

Parameters:
KEYLEN, 3, key length in bytes; key port width is 8*KEYLEN.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  start request; accepted only when rdy=1
rdy  output  1  1 = idle and able to accept en
key  input  8*KEYLEN  cipher key; byte 0 = key[8*KEYLEN-1 -: 8] (MSB first)
s_addr  output  8  S memory address
s_rddata  input  8  S memory read data, valid the cycle after s_addr is presented with s_wren=0
s_wrdata  output  8  S memory write data
s_wren  output  1  S memory write enable; write occurs at the rising edge ending the cycle

Behaviour:
- Reset (rst=1 at a rising edge, any state): state=IDLE, rdy=1, s_wren=0, s_addr=0, s_wrdata=0, i=0, j=0. Reset mid-operation abandons the permutation; memory contents are left as-is.
- Algorithm: j=0; for i=0..255: j=(j+S[i]+keybyte[i mod KEYLEN]) mod 256; swap S[i],S[j].
- All sums are 8-bit, wrap mod 256. i is 8-bit; termination is detected at i==255, not by overflow.
- Handshake: en is sampled at the rising edge while rdy=1. On accept: key latched into an internal register, i=0, j=0, rdy=0 from the next cycle.
  - en while rdy=0 is ignored.
  - key changes after accept are ignored.
- States, one cycle each, 6 cycles per iteration:
  - IDLE: rdy=1, s_wren=0. On en -> READ_SI.
  - READ_SI: s_addr=i, s_wren=0 -> CALC_J.
  - CALC_J: si<=s_rddata; j<=j+s_rddata+keybyte[i mod KEYLEN] -> READ_SJ.
  - READ_SJ: s_addr=j (updated), s_wren=0 -> CAPT_SJ.
  - CAPT_SJ: sj<=s_rddata -> WRITE_SI.
  - WRITE_SI: s_addr=i, s_wrdata=sj, s_wren=1 -> WRITE_SJ.
  - WRITE_SJ: s_addr=j, s_wrdata=si, s_wren=1. If i==255 -> IDLE; else i<=i+1 -> READ_SI.
- i mod KEYLEN is tracked by a separate wrapping counter (0..KEYLEN-1), reset to 0 on accept. No divider.
- i==j: both writes store the same value; S is unchanged. No special-case logic.
- Latency: if en is accepted at edge k, WRITE_SJ for i=255 occupies cycle k+1536 (edge-relative). rdy=1 from the cycle after, i.e. exactly 1536 busy cycles.
- s_wren is high only in the WRITE_* states: exactly 512 write cycles per run.
- Back-to-back: en held high continuously starts a new run on the first IDLE cycle after completion.
- Outputs s_addr and s_wrdata are don't-care when s_wren=0, except during READ_* states.

Test Plan:
- Identity S, key=24'h000018, KEYLEN=3 -> i=0,1 rewrite unchanged values; i=2 gives j=0x1B: write addr 0x02 data 0x1B, then addr 0x1B data 0x02. Full final S matches a software reference model byte-for-byte.
- Identity S, key=24'h000000 -> i=2 gives j=3: writes addr2=3, addr3=2. Final S matches model; i==j iterations (i=0,1) leave S unchanged.
- Cycle count: pulse en for one cycle with rdy=1 -> rdy low exactly 1536 cycles, s_wren high exactly 512 cycles, rdy returns to 1.
- Busy protection: assert en and change key to 24'hFFFFFF at cycle 100 of a run -> no restart; final S equals the original-key result.
- Reset mid-run: rst=1 at cycle 700 -> next cycle rdy=1, s_wren=0. Re-init S, restart with key 24'h000018 -> result identical to scenario 1.
- Back-to-back: en held high over two runs -> second run starts in the first IDLE cycle. Final S equals the model applied twice.

Source files
------------

// File: rtl/ksa_core.sv
// ============================================================================
// Module      : ksa_core
// Description : ARC4 key-scheduling stage; permutes the 256-byte S memory
//               in place under a KEYLEN-byte key using an en/rdy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ksa_core #(
    parameter int KEYLEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  rdy,
    input  logic [8*KEYLEN-1:0]   key,
    output logic [7:0]            s_addr,
    input  logic [7:0]            s_rddata,
    output logic [7:0]            s_wrdata,
    output logic                  s_wren
);

    localparam int KIW = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ_SI  = 3'd1,
        S_CALC_J   = 3'd2,
        S_READ_SJ  = 3'd3,
        S_CAPT_SJ  = 3'd4,
        S_WRITE_SI = 3'd5,
        S_WRITE_SJ = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          i_q, i_d;
    logic [7:0]          j_q, j_d;
    logic [7:0]          si_q, si_d;
    logic [7:0]          sj_q, sj_d;
    logic [8*KEYLEN-1:0] key_q, key_d;
    logic [KIW-1:0]      kidx_q, kidx_d;
    logic [7:0]          keybyte;

    // Byte 0 of the key sits in the most significant byte of the port.
    always_comb begin
        keybyte = 8'd0;
        for (int k = 0; k < KEYLEN; k++) begin
            if (kidx_q == KIW'(k)) begin
                keybyte = key_q[8*(KEYLEN-k)-1 -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            key_q   <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
            kidx_q  <= kidx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        key_d    = key_q;
        kidx_d   = kidx_q;
        rdy      = 1'b0;
        s_addr   = i_q;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;

        case (state_q)
            S_IDLE: begin
                rdy    = 1'b1;
                s_addr = 8'd0;
                if (en) begin
                    key_d   = key;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    kidx_d  = '0;
                    state_d = S_READ_SI;
                end
            end
            S_READ_SI: begin
                s_addr  = i_q;
                state_d = S_CALC_J;
            end
            S_CALC_J: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata + keybyte;
                state_d = S_READ_SJ;
            end
            S_READ_SJ: begin
                s_addr  = j_q;
                state_d = S_CAPT_SJ;
            end
            S_CAPT_SJ: begin
                sj_d    = s_rddata;
                state_d = S_WRITE_SI;
            end
            S_WRITE_SI: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = S_WRITE_SJ;
            end
            S_WRITE_SJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                if (i_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIW'(KEYLEN-1)) ? '0 : kidx_q + KIW'(1);
                    state_d = S_READ_SI;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ksa_core.sv
// ============================================================================
// Module      : tb_ksa_core
// Description : Directed self-checking bench for ksa_core with an S memory
//               model and a software key-schedule reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ksa_core;

    localparam int KEYLEN = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en  = 1'b0;
    logic                rdy;
    logic [8*KEYLEN-1:0] key = '0;
    logic [7:0]          s_addr;
    logic [7:0]          s_rddata = 8'd0;
    logic [7:0]          s_wrdata;
    logic                s_wren;

    logic [7:0]  mem   [256];
    logic [7:0]  ref_s [256];
    logic        init_req = 1'b0;
    logic [15:0] wlog [$];

    int n_checks = 0;
    int n_fail   = 0;
    int busy, writes;

    ksa_core #(.KEYLEN(KEYLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rdy      (rdy),
        .key      (key),
        .s_addr   (s_addr),
        .s_rddata (s_rddata),
        .s_wrdata (s_wrdata),
        .s_wren   (s_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (s_wren) begin
            mem[s_addr] <= s_wrdata;
        end
        s_rddata <= mem[s_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic init_s();
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
        for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
    endtask

    task automatic ksa_model(input logic [23:0] k);
        logic [7:0] j, t, kb;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            kb = k[23 - 8*(i % 3) -: 8];
            j = j + ref_s[i] + kb;
            t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
        end
    endtask

    task automatic compare_s(input string tag);
        int bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) bad++;
        check(tag, bad, 0);
    endtask

    // Entered at the first negedge after the accepting edge; returns at the
    // first negedge with rdy=1. inj_kind 1 = en+key poke, 2 = reset.
    task automatic run_wait(input int inj_at, input int inj_kind,
                            output int nbusy, output int nwr);
        nbusy = 0; nwr = 0;
        wlog.delete();
        for (int c = 0; c < 4000; c++) begin
            if (rdy) break;
            nbusy++;
            if (s_wren) begin
                nwr++;
                wlog.push_back({s_addr, s_wrdata});
            end
            if (inj_kind == 1 && nbusy == inj_at) begin
                en = 1'b1; key = 24'hFFFFFF;
            end
            if (inj_kind == 1 && nbusy == inj_at + 1) en = 1'b0;
            if (inj_kind == 2 && nbusy == inj_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_rdy", rdy, 1);
                check("rst_wren", s_wren, 0);
                check("rst_addr", s_addr, 0);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("run_done", rdy, 1);
    endtask

    task automatic start(input logic [23:0] k);
        @(negedge clk) begin key = k; en = 1'b1; end
        @(negedge clk) en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rdy", rdy, 1);
        check("reset_wren", s_wren, 0);
        check("reset_addr", s_addr, 0);
        check("reset_wrdata", s_wrdata, 0);
        rst = 1'b0;

        // Scenario 1: key 000018, j reaches 0x1B at i=2
        init_s();
        start(24'h000018);
        run_wait(0, 0, busy, writes);
        check("s1_busy", busy, 1536);
        check("s1_writes", writes, 512);
        check("s1_w0", wlog[0], 16'h0000);
        check("s1_w4", wlog[4], 16'h021B);
        check("s1_w5", wlog[5], 16'h1B02);
        ksa_model(24'h000018);
        compare_s("s1_final");
        check("s1_s02", mem[2], 8'h1B);
        check("s1_rdy_back", rdy, 1);

        // Scenario 2: all-zero key, i==j for i=0,1
        init_s();
        start(24'h000000);
        run_wait(0, 0, busy, writes);
        check("s2_w2", wlog[2], 16'h0101);
        check("s2_w4", wlog[4], 16'h0203);
        check("s2_w5", wlog[5], 16'h0302);
        ksa_model(24'h000000);
        compare_s("s2_final");

        // Busy protection: en and new key mid-run are ignored
        init_s();
        start(24'h000018);
        run_wait(100, 1, busy, writes);
        check("bp_busy", busy, 1536);
        ksa_model(24'h000018);
        compare_s("bp_final");
        @(negedge clk);
        check("bp_no_restart", rdy, 1);

        // Reset mid-run, then a clean restart
        init_s();
        start(24'h000018);
        run_wait(700, 2, busy, writes);
        init_s();
        start(24'h000018);
        run_wait(0, 0, busy, writes);
        check("rr_busy", busy, 1536);
        ksa_model(24'h000018);
        compare_s("rr_final");

        // Back-to-back with en held high
        init_s();
        @(negedge clk) begin key = 24'h000018; en = 1'b1; end
        @(negedge clk);
        run_wait(0, 0, busy, writes);
        check("bb_busy1", busy, 1536);
        @(negedge clk);
        check("bb_restart", rdy, 0);
        en = 1'b0;
        run_wait(0, 0, busy, writes);
        check("bb_busy2", busy, 1536);
        ksa_model(24'h000018);
        ksa_model(24'h000018);
        compare_s("bb_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
